// File: rtl/vga_sync_stream.sv
// vga_sync_stream: VGA timing generator that streams pixels from an upstream
// non-FWFT FIFO and locks the picture to the start-of-frame flag (bit CD).
// The FSM hunts for a SOF word (SEEK), waits for the frame origin (ALIGN),
// then reads one word per display pixel (RUN).
// Optional statistics counters are built when VGA_SYNC_STATS_EN is defined.
module vga_sync_stream #(
    parameter int CD = 12,
    parameter int HD = 640,
    parameter int HF = 16,
    parameter int HB = 48,
    parameter int HR = 96,
    parameter int VD = 480,
    parameter int VF = 10,
    parameter int VB = 33,
    parameter int VR = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fifo_empty,
    input  logic [CD:0]   fifo_rd_data,
    output logic          fifo_rd_ack,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CD-1:0] rgb,
    output logic          locked,
    output logic [15:0]   underflow_cnt,
    output logic [15:0]   resync_cnt
);
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    typedef enum logic [1:0] {SEEK, ALIGN, RUN} state_t;

    state_t        state;
    logic          run_en;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [CD-1:0] hold_q;

    logic disp_p0, origin_p0, hs_p0, vs_p0, show_p0;
    logic vld_p1, run_rd_p1, show_p1, hold_p1, origin_p1, hs_p1, vs_p1;
    logic sof_in, seek_sof, bad_ret, align_go, underflow, good_rd;

    // Chooses the colour for the output register; blanked or rejected pixels are zero.
    function automatic logic [CD-1:0] out_pixel(input logic          show,
                                                input logic          from_hold,
                                                input logic          good,
                                                input logic [CD-1:0] hold_pix,
                                                input logic [CD-1:0] fifo_pix);
        if (!show)
            return '0;
        if (from_hold)
            return hold_pix;
        if (good)
            return fifo_pix;
        return '0;
    endfunction

    // Stage p0: counter position, read request, sync decode
    assign disp_p0   = run_en && (h_cnt < HW'(HD)) && (v_cnt < VW'(VD));
    assign origin_p0 = run_en && (h_cnt == '0) && (v_cnt == '0);
    assign hs_p0     = !((h_cnt >= HW'(HD + HF)) && (h_cnt < HW'(HD + HF + HR)));
    assign vs_p0     = !((v_cnt >= VW'(VD + VF)) && (v_cnt < VW'(VD + VF + VR)));

    // Word returned this cycle (read issued last cycle); SEEK reads are the non-RUN ones.
    assign sof_in    = fifo_rd_data[CD];
    assign seek_sof  = vld_p1 && !run_rd_p1 && sof_in;
    assign bad_ret   = run_rd_p1 && (origin_p1 ? !sof_in : sof_in);
    assign good_rd   = run_rd_p1 && !bad_ret;
    assign align_go  = (state == ALIGN) && origin_p0;
    assign underflow = (state == RUN) && disp_p0 && fifo_empty && !bad_ret;
    assign show_p0   = disp_p0 && (((state == RUN) && !bad_ret) || align_go);

    // Read request: suppressed while a SOF or a rejected word is arriving so the
    // word behind it stays in the FIFO for the new alignment.
    always_comb begin
        fifo_rd_ack = 1'b0;
        case (state)
            SEEK:    fifo_rd_ack = disp_p0 && !fifo_empty && !seek_sof;
            RUN:     fifo_rd_ack = disp_p0 && !fifo_empty && !bad_ret;
            default: fifo_rd_ack = 1'b0;
        endcase
    end

    // Holds counting off until the first edge after reset release, so (0,0) gets a full cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            run_en <= 1'b0;
        else
            run_en <= 1'b1;
    end

    // Free-running pixel/line counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run_en) begin
            if (h_cnt == HW'(HT - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(VT - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Frame-lock FSM; returned-word checks take priority over underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= SEEK;
            locked <= 1'b0;
        end else begin
            case (state)
                SEEK: begin
                    if (seek_sof)
                        state <= ALIGN;
                end
                ALIGN: begin
                    if (align_go) begin
                        state  <= RUN;
                        locked <= 1'b1;
                    end
                end
                RUN: begin
                    if (bad_ret) begin
                        state  <= sof_in ? ALIGN : SEEK;
                        locked <= 1'b0;
                    end else if (underflow) begin
                        state  <= SEEK;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEEK;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Captures the SOF word that will be shown at the next frame origin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold_q <= '0;
        else if (seek_sof || (bad_ret && sof_in))
            hold_q <= fifo_rd_data[CD-1:0];
    end

    // Stage p1: FIFO read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            run_rd_p1 <= 1'b0;
            show_p1   <= 1'b0;
            hold_p1   <= 1'b0;
            origin_p1 <= 1'b0;
            hs_p1     <= 1'b1;
            vs_p1     <= 1'b1;
        end else begin
            vld_p1    <= fifo_rd_ack;
            run_rd_p1 <= fifo_rd_ack && (state == RUN);
            show_p1   <= show_p0;
            hold_p1   <= align_go;
            origin_p1 <= origin_p0;
            hs_p1     <= hs_p0;
            vs_p1     <= vs_p0;
        end
    end

    // Stage p2: registered video outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            rgb      <= '0;
        end else begin
            hsync    <= hs_p1;
            vsync    <= vs_p1;
            video_on <= show_p1;
            rgb      <= out_pixel(show_p1, hold_p1, good_rd, hold_q, fifo_rd_data[CD-1:0]);
        end
    end

`ifdef VGA_SYNC_STATS_EN
    // Saturating increment for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts underflow events and SOF resynchronisations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_cnt <= '0;
            resync_cnt    <= '0;
        end else begin
            if (underflow)
                underflow_cnt <= sat_inc(underflow_cnt);
            if (bad_ret)
                resync_cnt <= sat_inc(resync_cnt);
        end
    end
`else
    assign underflow_cnt = '0;
    assign resync_cnt    = '0;
`endif

endmodule

// File: tb/tb_vga_sync_stream.sv
// Bench for vga_sync_stream on a reduced 15x8 raster (8x4 visible).
module tb_vga_sync_stream;
    localparam int CD = 4;
`ifdef VGA_SYNC_STATS_EN
    localparam int STATS_EXP = 1;
`else
    localparam int STATS_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fifo_empty;
    logic [CD:0]   fifo_rd_data = '0;
    logic          fifo_rd_ack;
    logic          hsync, vsync, video_on, locked;
    logic [CD-1:0] rgb;
    logic [15:0]   underflow_cnt, resync_cnt;

    vga_sync_stream #(
        .CD(CD), .HD(8), .HF(2), .HB(2), .HR(3),
        .VD(4), .VF(1), .VB(1), .VR(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_ack(fifo_rd_ack),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
        .locked(locked), .underflow_cnt(underflow_cnt), .resync_cnt(resync_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model (non-FWFT): data appears the cycle after the ack.
    logic [CD:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_base = 0;
    int cyc;
    int starve_at = -100;
    int bad_rd = 0;

    assign fifo_empty = (wr_ptr == rd_ptr) || (cyc == starve_at);

    always @(posedge clk) begin
        if (fifo_rd_ack) begin
            fifo_rd_data <= mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
            if (fifo_empty)
                bad_rd <= bad_rd + 1;
        end
    end

    // Cycle index: 0 is the first cycle the counters sit at (0,0) after release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cyc <= -1;
        else
            cyc <= cyc + 1;
    end

    typedef struct {
        int   scn;
        int   c;
        logic hs;
        logic vs;
        logic von;
        int   rgbv;
        logic lk;
        int   rd;
    } vec_t;

    vec_t tbl[$];
    int errors = 0;
    int checks = 0;
    int hs_lo, vs_lo, rd_hi, lk_hi;

    function automatic void add(input int scn, input int c, input logic hs, input logic vs,
                                input logic von, input int rgbv, input logic lk, input int rd);
        vec_t v;
        v.scn = scn; v.c = c; v.hs = hs; v.vs = vs; v.von = von;
        v.rgbv = rgbv; v.lk = lk; v.rd = rd;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != c) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, c);
        end
    endtask

    task automatic push(input logic sof, input int val);
        mem[wr_ptr[9:0]] = {sof, CD'(val)};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_release();
        @(negedge clk);
        rd_base = rd_ptr;
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rd_ack"}, fifo_rd_ack, 0);
        chk({tag, " hsync"}, hsync, 1);
        chk({tag, " vsync"}, vsync, 1);
        chk({tag, " video_on"}, video_on, 0);
        chk({tag, " rgb"}, rgb, 0);
        chk({tag, " locked"}, locked, 0);
        chk({tag, " underflow_cnt"}, underflow_cnt, 0);
        chk({tag, " resync_cnt"}, resync_cnt, 0);
    endtask

    task automatic run_table(input int scn);
        foreach (tbl[i]) begin
            if (tbl[i].scn == scn) begin
                wait_cyc(tbl[i].c);
                chk($sformatf("s%0d c%0d hsync", scn, tbl[i].c), hsync, tbl[i].hs);
                chk($sformatf("s%0d c%0d vsync", scn, tbl[i].c), vsync, tbl[i].vs);
                chk($sformatf("s%0d c%0d video_on", scn, tbl[i].c), video_on, tbl[i].von);
                chk($sformatf("s%0d c%0d rgb", scn, tbl[i].c), rgb, tbl[i].rgbv);
                chk($sformatf("s%0d c%0d locked", scn, tbl[i].c), locked, tbl[i].lk);
                if (tbl[i].rd >= 0)
                    chk($sformatf("s%0d c%0d reads", scn, tbl[i].c), rd_ptr - rd_base, tbl[i].rd);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenario 1: 3 junk words, frame F, frame G; starve at (2,1) of frame G.
        //   scn  cyc  hs vs von rgb lk reads
        add(1,   6,  1, 1, 0,  0, 0,  4);
        add(1,  12,  0, 1, 0,  0, 0,  4);
        add(1,  15,  1, 1, 0,  0, 0,  4);
        add(1,  77,  1, 0, 0,  0, 0,  4);
        add(1, 106,  1, 0, 0,  0, 0,  4);
        add(1, 107,  1, 1, 0,  0, 0,  4);
        add(1, 121,  1, 1, 0,  0, 1,  4);
        add(1, 122,  1, 1, 1,  1, 1,  5);
        add(1, 123,  1, 1, 1,  2, 1, -1);
        add(1, 129,  1, 1, 1,  8, 1, -1);
        add(1, 130,  1, 1, 0,  0, 1, -1);
        add(1, 137,  1, 1, 1,  9, 1, -1);
        add(1, 150,  1, 1, 0,  0, 1, 19);
        add(1, 242,  1, 1, 1,  1, 1, -1);
        add(1, 258,  1, 1, 1, 10, 0, -1);
        add(1, 259,  1, 1, 1,  0, 0, -1);
        add(1, 260,  1, 1, 0,  0, 0, -1);
        // Scenario 2: SOF word X inserted at (5,0), next frame H aligned to X.
        add(2, 126,  1, 1, 1,  5, 1,  6);
        add(2, 127,  1, 1, 1,  0, 0,  6);
        add(2, 128,  1, 1, 0,  0, 0,  6);
        add(2, 241,  1, 1, 0,  0, 1,  6);
        add(2, 242,  1, 1, 1, 15, 1,  7);
        add(2, 243,  1, 1, 1,  9, 1, -1);
        add(2, 248,  1, 1, 1, 14, 1, -1);
        add(2, 273,  1, 1, 1,  9, 1, -1);
        // Scenario 3: restart after mid-frame reset, FIFO empty.
        add(3,   5,  1, 1, 0,  0, 0,  0);
        add(3,  11,  1, 1, 0,  0, 0,  0);
        add(3,  12,  0, 1, 0,  0, 0,  0);

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #11;
        chk_reset_vals("initial reset");

        // Scenario 0: empty FIFO for two frames.
        hs_lo = 0; vs_lo = 0; rd_hi = 0; lk_hi = 0;
        do_release();
        for (int i = 0; i < 240; i++) begin
            wait_cyc(i);
            hs_lo += int'(!hsync);
            vs_lo += int'(!vsync);
            rd_hi += int'(fifo_rd_ack);
            lk_hi += int'(locked);
        end
        chk("empty hsync low cycles", hs_lo, 48);
        chk("empty vsync low cycles", vs_lo, 60);
        chk("empty rd_ack cycles", rd_hi, 0);
        chk("empty locked cycles", lk_hi, 0);
        chk("empty reads", rd_ptr - rd_base, 0);

        // Scenario 1
        reset_n = 1'b0;
        wr_ptr = rd_ptr;
        for (int n = 0; n < 3; n++) push(1'b0, 9);
        for (int f = 0; f < 2; f++)
            for (int n = 0; n < 32; n++) push(n == 0, (n + 1) % 16);
        starve_at = 257;
        do_release();
        run_table(1);
        chk("underflow_cnt after starve", underflow_cnt, STATS_EXP);
        chk("resync_cnt after starve", resync_cnt, 0);

        // Scenario 2
        reset_n = 1'b0;
        starve_at = -100;
        #1;
        chk("underflow_cnt in reset", underflow_cnt, 0);
        wr_ptr = rd_ptr;
        for (int n = 0; n < 5; n++) push(n == 0, n + 1);
        push(1'b1, 15);
        for (int n = 1; n < 32; n++) push(1'b0, (n + 8) % 16);
        do_release();
        run_table(2);
        chk("resync_cnt after SOF insert", resync_cnt, STATS_EXP);
        chk("rd_ack before mid reset", fifo_rd_ack, 1);
        #1 reset_n = 1'b0;
        #1;
        chk_reset_vals("mid-frame reset");
        repeat (3) @(posedge clk);
        #1;
        chk("reset held rd_ack", fifo_rd_ack, 0);
        chk("reset held video_on", video_on, 0);
        wr_ptr = rd_ptr;

        // Scenario 3
        do_release();
        run_table(3);
        chk("reads while FIFO empty", bad_rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
